// File: rtl/mips_pkg.sv
// Shared constants for the boot loader and instruction memory.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: loader FSM state encoding, bytes per IMEM word, default IMEM depth.
package mips_pkg;

    localparam int WORD_BYTES = 4;
    localparam int IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words and flags the 4th byte.
// Latency: combinational word/word_done on the 4th byte; history registered per accepted byte.
// Backpressure: none; it consumes whatever 'take' presents, one byte per cycle.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clr          synchronous clear of byte count and history
//   take         a byte transfers this cycle
//   din          the byte
//   word         assembled big-endian word (valid when word_done)
//   word_done    take on the last byte of a word
module imem_loader_byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int CW = $clog2(WORD_BYTES);

    logic [CW-1:0] cnt;
    // Only three bytes of history are needed: the 4th byte goes straight
    // into the output word on the edge it arrives.
    logic [23:0]   sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (take) begin
            cnt <= cnt + CW'(1);
            sr  <= {sr[15:0], din};
        end
    end

    assign word      = {sr, din};
    assign word_done = take && (cnt == CW'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header (16-bit word count) + big-endian image bytes -> IMEM writes, then releases the core.
// Latency: IMEM write strobe the cycle after the 4th byte of each word; cpuRun_out one cycle after DONE.
// Backpressure: byteReady_out depends on state only; sustains one byte per cycle, writes never stall.
// Optional: define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte (CSUM state).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start_in                   begin a load (honoured in IDLE/DONE/ERROR)
//   byte_in, byteValid_in,
//   byteReady_out              byte stream handshake
//   imemWrite_out, imemAddr_out,
//   imemData_out               IMEM write port
//   cpuRun_out                 core may run
//   busy_out                   load in progress
//   error_out                  sticky error, cleared by start
module imem_loader
    import mips_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic [7:0]  byte_in,
    input  logic        byteValid_in,
    output logic        byteReady_out,
    output logic        imemWrite_out,
    output logic [31:0] imemAddr_out,
    output logic [31:0] imemData_out,
    output logic        cpuRun_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam int          IW      = $clog2(DEPTH) + 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t        state;
    logic          hdr_cnt;
    logic [7:0]    hdr_hi;
    logic [15:0]   word_cnt;
    logic [IW-1:0] word_idx;

    logic          take;
    logic          start_ok;
    logic [15:0]   n_next;
    logic [31:0]   word;
    logic          word_done;
    logic          last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
    assign byteReady_out = (state == HDR) || (state == LOAD) || (state == CSUM);
`else
    assign byteReady_out = (state == HDR) || (state == LOAD);
`endif

    assign busy_out  = byteReady_out;
    assign take      = byteValid_in && byteReady_out;
    assign start_ok  = start_in && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign n_next    = {hdr_hi, byte_in};
    assign last_word = (16'(word_idx) + 16'd1) == word_cnt;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (reset),
        .clr       (start_ok),
        .take      (take && (state == LOAD)),
        .din       (byte_in),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hdr_cnt       <= 1'b0;
            hdr_hi        <= '0;
            word_cnt      <= '0;
            word_idx      <= '0;
            imemWrite_out <= 1'b0;
            imemAddr_out  <= BASE_ADDR;
            imemData_out  <= '0;
            cpuRun_out    <= 1'b0;
            error_out     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            imemWrite_out <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_in) begin
                        state      <= HDR;
                        hdr_cnt    <= 1'b0;
                        word_cnt   <= '0;
                        word_idx   <= '0;
                        error_out  <= 1'b0;
                        cpuRun_out <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end else if (state == DONE) begin
                        // Registered: rises the cycle after DONE is entered.
                        cpuRun_out <= 1'b1;
                    end
                end
                HDR: begin
                    if (take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_in;
`endif
                        if (!hdr_cnt) begin
                            hdr_hi  <= byte_in;
                            hdr_cnt <= 1'b1;
                        end else begin
                            word_cnt <= n_next;
                            if (n_next == 16'd0) begin
                                state <= DONE;
                            end else if ({1'b0, n_next} > DEPTH_W) begin
                                state     <= ERROR;
                                error_out <= 1'b1;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_in;
`endif
                        if (word_done) begin
                            imemData_out  <= word;
                            imemAddr_out  <= BASE_ADDR + 32'({word_idx, 2'b00});
                            imemWrite_out <= 1'b1;
                            // The HDR range check keeps word_idx <= DEPTH, so it never wraps.
                            word_idx      <= word_idx + IW'(1);
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= CSUM;
`else
                                state <= DONE;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (take) begin
                        if (byte_in == csum) begin
                            state <= DONE;
                        end else begin
                            state     <= ERROR;
                            error_out <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus random loads against a queue-based model.
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in;
    logic [7:0]  byte_in;
    logic        byteValid_in;
    logic        byteReady_out;
    logic        imemWrite_out;
    logic [31:0] imemAddr_out;
    logic [31:0] imemData_out;
    logic        cpuRun_out;
    logic        busy_out;
    logic        error_out;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_in      (start_in),
        .byte_in       (byte_in),
        .byteValid_in  (byteValid_in),
        .byteReady_out (byteReady_out),
        .imemWrite_out (imemWrite_out),
        .imemAddr_out  (imemAddr_out),
        .imemData_out  (imemData_out),
        .cpuRun_out    (cpuRun_out),
        .busy_out      (busy_out),
        .error_out     (error_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe seen on the falling edge is one IMEM write.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          dbl      = 0;
    int          rdy_drop = 0;
    logic        prev_wr  = 1'b0;

    always @(negedge clk) begin
        if (imemWrite_out) begin
            obs_addr.push_back(imemAddr_out);
            obs_data.push_back(imemData_out);
            if (prev_wr) dbl++;
        end
        prev_wr = imemWrite_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // Entered and left on a falling edge; the byte transfers on the rising edge in between.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit with_start);
        int t;
        if (gap) begin
            byteValid_in = 1'b0;
            byte_in      = 8'($urandom);
            @(negedge clk);
            if (!byteReady_out) rdy_drop++;
        end
        byteValid_in = 1'b1;
        byte_in      = b;
        start_in     = with_start;
        t = 0;
        while (!byteReady_out && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byteReady_out) check("rdy_timeout", 32'd0, 32'd1);
        @(negedge clk);
        byteValid_in = 1'b0;
        start_in     = 1'b0;
        byte_in      = 8'($urandom);
    endtask

    // Model: header N, image of 4N bytes; N>DEPTH -> error with no writes;
    // otherwise word i lands at BASE+4i as the big-endian join of bytes 4i..4i+3.
    task automatic run_load(input int n, input logic [7:0] data[$], input bit gaps,
                            input bit mid_start, input bit sum_ok);
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
        bit         exp_err;
        int         nw;
        obs_addr.delete();
        obs_data.delete();
        dbl      = 0;
        rdy_drop = 0;
        pulse_start();
        check("busy_after_start", busy_out, 1);
        check("err_cleared", error_out, 0);
        check("run_dropped", cpuRun_out, 0);
        hi = 8'(n >> 8);
        lo = 8'(n);
        x  = hi ^ lo;
        send_byte(hi, 1'b0, 1'b0);
        send_byte(lo, gaps, 1'b0);
        exp_err = (n > DEPTH);
        nw      = exp_err ? 0 : n;
        if (!exp_err && n > 0) begin
            for (int i = 0; i < 4 * n; i++) begin
                x ^= data[i];
                send_byte(data[i], gaps && ($urandom_range(0, 1) == 1), mid_start && (i == 5));
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(sum_ok ? x : ~x, gaps, 1'b0);
            exp_err = !sum_ok;
`endif
        end
        check("rdy_after", byteReady_out, 0);
        check("busy_after", busy_out, 0);
        check("err", error_out, 32'(exp_err));
        check("run_early", cpuRun_out, 0);
        @(negedge clk);
        check("run", cpuRun_out, 32'(!exp_err));
        check("wr_count", obs_addr.size(), nw);
        for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
            check("wr_addr", obs_addr[i], BASE + 32'(4 * i));
            check("wr_data", obs_data[i], {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]});
        end
        check("dbl_strobe", dbl, 0);
        check("rdy_drop", rdy_drop, 0);
    endtask

    task automatic check_reset_vals();
        check("rst_rdy", byteReady_out, 0);
        check("rst_wr", imemWrite_out, 0);
        check("rst_addr", imemAddr_out, BASE);
        check("rst_data", imemData_out, 0);
        check("rst_run", cpuRun_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_err", error_out, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        int         n;
        reset        = 1'b0;
        start_in     = 1'b0;
        byteValid_in = 1'b0;
        byte_in      = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);

        // Nominal two-word image, back-to-back.
        q = '{8'h3C, 8'h08, 8'h00, 8'h10, 8'h8D, 8'h09, 8'h00, 8'h00};
        run_load(2, q, 1'b0, 1'b0, 1'b1);
        if (obs_data.size() == 2) begin
            check("nom_w0", obs_data[0], 32'h3C080010);
            check("nom_w1", obs_data[1], 32'h8D090000);
            check("nom_a1", obs_addr[1], 32'h0000_0004);
        end

        // Same image with valid gaps and a start pulse during LOAD (ignored);
        // also restarts from DONE.
        run_load(2, q, 1'b1, 1'b1, 1'b1);

        // Bounds.
        q.delete();
        run_load(0, q, 1'b0, 1'b0, 1'b1);
        run_load(DEPTH + 1, q, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
        run_load(DEPTH, q, 1'b0, 1'b0, 1'b1);
        if (obs_addr.size() == DEPTH) check("last_addr", obs_addr[DEPTH-1], 32'h0000_03FC);

        // Reset mid-load after five data bytes.
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 1'b0, 1'b0);
        check("pre_rst_writes", obs_addr.size(), 1);
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, q, 1'b0, 1'b0, 1'b1);
        if (obs_data.size() == 1) begin
            check("post_rst_data", obs_data[0], 32'h01020304);
            check("post_rst_addr", obs_addr[0], BASE);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, q, 1'b0, 1'b0, 1'b1);
        run_load(1, q, 1'b0, 1'b0, 1'b0);
`endif

        // Random images.
        repeat (8) begin
            n = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            run_load(n, q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
